// File: rtl/ice40_himax_sched_pkg.sv
// rtl/ice40_himax_sched_pkg.sv - shared states, default widths and saturating increment
package ice40_himax_sched_pkg;

   localparam int DEF_SKIP_W    = 4;
   localparam int DEF_TIMEOUT_W = 20;
   localparam int DEF_CNT_W     = 16;

   typedef enum logic [2:0] {
      S_INIT = 3'd0,
      S_ARM  = 3'd1,
      S_CAP  = 3'd2,
      S_RUN  = 3'd3,
      S_ML   = 3'd4,
      S_RPT  = 3'd5
   } state_t;

   // Width-generic: caller zero-extends to 32 bits and truncates the result back.
   function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
      logic [31:0] max_val;
      max_val = (32'd1 << width) - 32'd1;
      return (value >= max_val) ? value : value + 32'd1;
   endfunction

endpackage

// File: rtl/ice40_himax_frame_sched_if.sv
// rtl/ice40_himax_frame_sched_if.sv - scheduler control/status bundle
interface ice40_himax_frame_sched_if
   import ice40_himax_sched_pkg::*;
#(
   parameter int SKIP_W    = DEF_SKIP_W,
   parameter int TIMEOUT_W = DEF_TIMEOUT_W,
   parameter int CNT_W     = DEF_CNT_W
);
   logic                 i_init_done;
   logic                 i_cam_vsync;
   logic [SKIP_W-1:0]    i_skip;
   logic [TIMEOUT_W-1:0] i_timeout;
   logic                 i_cap_done;
   logic                 i_ml_done;
   logic                 i_result_rdy;
   logic                 o_cap_en;
   logic                 o_ml_start;
   logic                 o_result_vld;
   logic                 o_err;
   logic [2:0]           o_state;
   logic [CNT_W-1:0]     o_frame_cnt;
   logic [CNT_W-1:0]     o_drop_cnt;

   modport master (
      output i_init_done, i_cam_vsync, i_skip, i_timeout, i_cap_done, i_ml_done, i_result_rdy,
      input  o_cap_en, o_ml_start, o_result_vld, o_err, o_state, o_frame_cnt, o_drop_cnt
   );

   modport slave (
      input  i_init_done, i_cam_vsync, i_skip, i_timeout, i_cap_done, i_ml_done, i_result_rdy,
      output o_cap_en, o_ml_start, o_result_vld, o_err, o_state, o_frame_cnt, o_drop_cnt
   );
endinterface

// File: rtl/ice40_himax_vsync_sync.sv
// rtl/ice40_himax_vsync_sync.sv - 2-flop synchronizer with rising-edge pulse
module ice40_himax_vsync_sync (
   input  logic clk,
   input  logic resetn,
   input  logic strobe,
   output logic rise
);
   logic meta, sync, sync_d;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         meta   <= 1'b0;
         sync   <= 1'b0;
         sync_d <= 1'b0;
      end else begin
         meta   <= strobe;
         sync   <= meta;
         sync_d <= sync;
      end
   end

   assign rise = sync & ~sync_d;
endmodule

// File: rtl/ice40_himax_frame_sched.sv
// rtl/ice40_himax_frame_sched.sv - capture / inference / report sequencer with skip, watchdog and drop count
module ice40_himax_frame_sched
   import ice40_himax_sched_pkg::*;
#(
   parameter int SKIP_W    = DEF_SKIP_W,
   parameter int TIMEOUT_W = DEF_TIMEOUT_W,
   parameter int CNT_W     = DEF_CNT_W
) (
   input  logic                      clk,
   input  logic                      resetn,
   ice40_himax_frame_sched_if.slave  bus
);
   logic                 rst_meta, rst_sync;
   logic                 vs_rise;
   state_t               state, state_n;
   logic [SKIP_W-1:0]    skip_cnt, skip_n;
   logic [TIMEOUT_W-1:0] wd, wd_n;
   logic [CNT_W-1:0]     frame_cnt, frame_n;
   logic [CNT_W-1:0]     drop_cnt, drop_n;
   logic                 expire;

   // Reset asserts asynchronously but releases on a clock edge.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rst_meta <= 1'b0;
         rst_sync <= 1'b0;
      end else begin
         rst_meta <= 1'b1;
         rst_sync <= rst_meta;
      end
   end

   ice40_himax_vsync_sync u_vsync (
      .clk    (clk),
      .resetn (rst_sync),
      .strobe (bus.i_cam_vsync),
      .rise   (vs_rise)
   );

   always_ff @(posedge clk or negedge rst_sync) begin
      if (!rst_sync) begin
         state     <= S_INIT;
         skip_cnt  <= '0;
         wd        <= '0;
         frame_cnt <= '0;
         drop_cnt  <= '0;
      end else begin
         state     <= state_n;
         skip_cnt  <= skip_n;
         wd        <= wd_n;
         frame_cnt <= frame_n;
         drop_cnt  <= drop_n;
      end
   end

   always_comb begin
      state_n = state;
      skip_n  = skip_cnt;
      wd_n    = wd;
      frame_n = frame_cnt;
      drop_n  = drop_cnt;
      expire  = 1'b0;

      if (vs_rise && (state == S_CAP || state == S_RUN || state == S_ML || state == S_RPT))
         drop_n = CNT_W'(sat_inc(32'(drop_cnt), CNT_W));

      if (!bus.i_init_done) begin
         state_n = S_INIT;
         skip_n  = '0;
      end else begin
         case (state)
            S_INIT: state_n = S_ARM;
            S_ARM: begin
               if (vs_rise) begin
                  if (skip_cnt == '0) begin
                     skip_n  = bus.i_skip;
                     state_n = S_CAP;
                  end else begin
                     skip_n = skip_cnt - SKIP_W'(1);
                  end
               end
            end
            S_CAP: if (bus.i_cap_done) state_n = S_RUN;
            S_RUN: begin
               wd_n    = '0;
               state_n = S_ML;
            end
            S_ML: begin
               // wd counts completed ML cycles, so expiry lands T+1 cycles after the start pulse.
               wd_n = wd + TIMEOUT_W'(1);
               if (bus.i_ml_done) begin
                  state_n = S_RPT;
               end else if (bus.i_timeout != '0 && wd == bus.i_timeout) begin
                  expire  = 1'b1;
                  state_n = S_ARM;
               end
            end
            S_RPT: begin
               if (bus.i_result_rdy) begin
                  frame_n = CNT_W'(sat_inc(32'(frame_cnt), CNT_W));
                  state_n = S_ARM;
               end
            end
            default: state_n = S_INIT;
         endcase
      end
   end

   assign bus.o_cap_en     = (state == S_CAP);
   assign bus.o_ml_start   = (state == S_RUN);
   assign bus.o_result_vld = (state == S_RPT);
   assign bus.o_err        = expire;
   assign bus.o_state      = state;
   assign bus.o_frame_cnt  = frame_cnt;
   assign bus.o_drop_cnt   = drop_cnt;
endmodule

// File: tb/tb_ice40_himax_frame_sched.sv
// tb/tb_ice40_himax_frame_sched.sv - scoreboard bench for the frame scheduler
module tb_ice40_himax_frame_sched;
   logic clk = 1'b0;
   logic resetn = 1'b0;

   ice40_himax_frame_sched_if bus ();

   ice40_himax_frame_sched dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int exp_frame = 0;
   int exp_drop = 0;
   int frame_q[$];
   int err_pulses = 0;

   always @(negedge clk) if (bus.o_err === 1'b1) err_pulses++;

   task automatic nclk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic vsync_pulse();
      bus.i_cam_vsync = 1'b1;
      nclk(4);
      bus.i_cam_vsync = 1'b0;
      nclk(2);
   endtask

   task automatic finish_frame(input int hold);
      int prev, hi, exp_v;
      bit stable, done;
      bus.i_result_rdy = (hold == 0);
      bus.i_ml_done = 1'b1;
      nclk(1);
      bus.i_ml_done = 1'b0;
      prev = exp_frame;
      exp_frame = exp_frame + 1;
      frame_q.push_back(exp_frame);
      checks++;
      if (bus.o_result_vld !== 1'b1) begin
         errors++;
         $display("FAIL result_vld_rise: got %b want 1", bus.o_result_vld);
      end
      hi = 0;
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
         nclk(1);
         if (bus.o_result_vld === 1'b1) hi++;
         if (bus.o_frame_cnt !== 16'(prev)) stable = 1'b0;
      end
      if (hold > 0) begin
         checks++;
         if (hi != hold || !stable) begin
            errors++;
            $display("FAIL backpressure_hold: vld_cycles %0d want %0d, frame_stable %0d want 1", hi, hold, stable);
         end
      end
      bus.i_result_rdy = 1'b1;
      done = 1'b0;
      for (int i = 0; i < 100; i++) begin
         nclk(1);
         if (bus.o_result_vld !== 1'b1) begin
            done = 1'b1;
            break;
         end
      end
      exp_v = frame_q.pop_front();
      checks++;
      if (!done || bus.o_frame_cnt !== 16'(exp_v) || bus.o_state !== 3'd1) begin
         errors++;
         $display("FAIL accept: done %0d frame_cnt %0d want %0d state %0d want 1", done, bus.o_frame_cnt, exp_v, bus.o_state);
      end
      checks++;
      if (bus.o_drop_cnt !== 16'(exp_drop)) begin
         errors++;
         $display("FAIL drop_cnt_after_frame: got %0d want %0d", bus.o_drop_cnt, exp_drop);
      end
   endtask

   task automatic run_frame(input int ml_delay, input int nv, input int hold);
      bus.i_cap_done = 1'b1;
      nclk(1);
      bus.i_cap_done = 1'b0;
      checks++;
      if (bus.o_ml_start !== 1'b1 || bus.o_state !== 3'd3) begin
         errors++;
         $display("FAIL ml_start: got %b state %0d want 1 state 3", bus.o_ml_start, bus.o_state);
      end
      nclk(1);
      checks++;
      if (bus.o_ml_start !== 1'b0 || bus.o_state !== 3'd4) begin
         errors++;
         $display("FAIL ml_state: ml_start %b state %0d want 0 state 4", bus.o_ml_start, bus.o_state);
      end
      for (int v = 0; v < nv; v++) begin
         vsync_pulse();
         exp_drop = exp_drop + 1;
      end
      nclk(ml_delay - 1 - 6 * nv);
      finish_frame(hold);
   endtask

   task automatic expect_cap(input string name);
      checks++;
      if (bus.o_cap_en !== 1'b1 || bus.o_state !== 3'd2) begin
         errors++;
         $display("FAIL %s: cap_en %b state %0d want 1 state 2", name, bus.o_cap_en, bus.o_state);
      end
   endtask

   task automatic test_reset();
      nclk(2);
      checks++;
      if (bus.o_state !== 3'd0 || bus.o_cap_en !== 1'b0 || bus.o_ml_start !== 1'b0 ||
          bus.o_result_vld !== 1'b0 || bus.o_err !== 1'b0 || bus.o_frame_cnt !== 16'd0 || bus.o_drop_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_values: state %0d cap %b ml %b vld %b err %b frame %0d drop %0d want all 0",
                  bus.o_state, bus.o_cap_en, bus.o_ml_start, bus.o_result_vld, bus.o_err, bus.o_frame_cnt, bus.o_drop_cnt);
      end
      resetn = 1'b1;
      nclk(4);
   endtask

   task automatic test_init_gating();
      for (int v = 0; v < 5; v++) begin
         vsync_pulse();
         checks++;
         if (bus.o_cap_en !== 1'b0) begin
            errors++;
            $display("FAIL init_gate_cap_%0d: got %b want 0", v, bus.o_cap_en);
         end
      end
      checks++;
      if (bus.o_state !== 3'd0 || bus.o_drop_cnt !== 16'd0) begin
         errors++;
         $display("FAIL init_gate_state: state %0d drop %0d want 0 0", bus.o_state, bus.o_drop_cnt);
      end
      bus.i_init_done = 1'b1;
      nclk(2);
      checks++;
      if (bus.o_state !== 3'd1) begin
         errors++;
         $display("FAIL init_to_arm: got %0d want 1", bus.o_state);
      end
      vsync_pulse();
      expect_cap("init_first_cap");
      run_frame(10, 0, 0);
   endtask

   task automatic test_skip();
      bit cap_q[$];
      int mskip, caps, f0, d0;
      bit exp_c;
      bus.i_skip = 4'd2;
      mskip = 0;
      caps = 0;
      f0 = exp_frame;
      d0 = bus.o_drop_cnt;
      for (int v = 1; v <= 9; v++) begin
         if (mskip == 0) begin
            cap_q.push_back(1'b1);
            mskip = 2;
         end else begin
            cap_q.push_back(1'b0);
            mskip--;
         end
         vsync_pulse();
         exp_c = cap_q.pop_front();
         checks++;
         if (bus.o_cap_en !== exp_c) begin
            errors++;
            $display("FAIL skip_vsync_%0d: cap_en %b want %b", v, bus.o_cap_en, exp_c);
         end
         if (bus.o_cap_en === 1'b1) begin
            caps++;
            run_frame(100, 0, 0);
         end
      end
      checks++;
      if (caps != 3 || exp_frame - f0 != 3 || bus.o_frame_cnt !== 16'(f0 + 3) || bus.o_drop_cnt !== 16'(d0)) begin
         errors++;
         $display("FAIL skip_totals: caps %0d want 3 frame %0d want %0d drop %0d want %0d",
                  caps, bus.o_frame_cnt, f0 + 3, bus.o_drop_cnt, d0);
      end
      bus.i_skip = 4'd0;
   endtask

   task automatic test_busy_drop();
      int d0;
      d0 = exp_drop;
      vsync_pulse();
      expect_cap("busy_cap");
      run_frame(100, 2, 0);
      checks++;
      if (bus.o_drop_cnt !== 16'(d0 + 2)) begin
         errors++;
         $display("FAIL busy_drop: got %0d want %0d", bus.o_drop_cnt, d0 + 2);
      end
   endtask

   task automatic test_watchdog();
      int cnt, e0;
      bit found;
      bus.i_timeout = 20'd50;
      vsync_pulse();
      expect_cap("wd_cap");
      bus.i_cap_done = 1'b1;
      nclk(1);
      bus.i_cap_done = 1'b0;
      checks++;
      if (bus.o_ml_start !== 1'b1) begin
         errors++;
         $display("FAIL wd_ml_start: got %b want 1", bus.o_ml_start);
      end
      found = 1'b0;
      cnt = 0;
      for (int i = 0; i < 200; i++) begin
         nclk(1);
         cnt++;
         if (bus.o_err === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
      checks++;
      if (!found || cnt != 51) begin
         errors++;
         $display("FAIL wd_expiry: found %0d after %0d clk want 51", found, cnt);
      end
      nclk(1);
      checks++;
      if (bus.o_err !== 1'b0 || bus.o_state !== 3'd1) begin
         errors++;
         $display("FAIL wd_recover: err %b state %0d want 0 state 1", bus.o_err, bus.o_state);
      end
      bus.i_timeout = 20'd0;
      e0 = err_pulses;
      vsync_pulse();
      expect_cap("wd0_cap");
      run_frame(30000, 0, 0);
      checks++;
      if (err_pulses != e0) begin
         errors++;
         $display("FAIL wd_disabled: err pulses %0d want 0", err_pulses - e0);
      end
   endtask

   task automatic test_backpressure();
      vsync_pulse();
      expect_cap("bp_cap");
      run_frame(12, 0, 20);
   endtask

   task automatic test_race_cap();
      bit seen;
      vsync_pulse();
      expect_cap("race_cap_cap");
      bus.i_cam_vsync = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         nclk(1);
         if (dut.vs_rise === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      bus.i_cap_done = 1'b1;
      nclk(1);
      bus.i_cap_done = 1'b0;
      bus.i_cam_vsync = 1'b0;
      exp_drop = exp_drop + 1;
      checks++;
      if (!seen || bus.o_state !== 3'd3 || bus.o_drop_cnt !== 16'(exp_drop)) begin
         errors++;
         $display("FAIL race_cap_vsync: seen %0d state %0d want 3 drop %0d want %0d", seen, bus.o_state, bus.o_drop_cnt, exp_drop);
      end
      nclk(3);
      finish_frame(0);
   endtask

   task automatic test_race_ml();
      bus.i_timeout = 20'd20;
      vsync_pulse();
      expect_cap("race_ml_cap");
      bus.i_cap_done = 1'b1;
      nclk(1);
      bus.i_cap_done = 1'b0;
      nclk(21);
      bus.i_ml_done = 1'b1;
      #1;
      checks++;
      if (bus.o_err !== 1'b0 || bus.o_state !== 3'd4) begin
         errors++;
         $display("FAIL race_ml_err: err %b state %0d want 0 state 4", bus.o_err, bus.o_state);
      end
      nclk(1);
      bus.i_ml_done = 1'b0;
      checks++;
      if (bus.o_state !== 3'd5 || bus.o_result_vld !== 1'b1) begin
         errors++;
         $display("FAIL race_ml_rpt: state %0d vld %b want 5 1", bus.o_state, bus.o_result_vld);
      end
      exp_frame = exp_frame + 1;
      nclk(1);
      checks++;
      if (bus.o_state !== 3'd1 || bus.o_frame_cnt !== 16'(exp_frame)) begin
         errors++;
         $display("FAIL race_ml_accept: state %0d frame %0d want 1 %0d", bus.o_state, bus.o_frame_cnt, exp_frame);
      end
      bus.i_timeout = 20'd0;
   endtask

   task automatic test_saturation();
      force dut.drop_cnt = 16'hFFFE;
      #1;
      release dut.drop_cnt;
      checks++;
      if (bus.o_drop_cnt !== 16'hFFFE) begin
         errors++;
         $display("FAIL sat_preload: got %h want fffe", bus.o_drop_cnt);
      end
      vsync_pulse();
      expect_cap("sat_cap");
      vsync_pulse();
      checks++;
      if (bus.o_drop_cnt !== 16'hFFFF) begin
         errors++;
         $display("FAIL sat_first: got %h want ffff", bus.o_drop_cnt);
      end
      vsync_pulse();
      vsync_pulse();
      checks++;
      if (bus.o_drop_cnt !== 16'hFFFF) begin
         errors++;
         $display("FAIL sat_hold: got %h want ffff", bus.o_drop_cnt);
      end
      exp_drop = 65535;
      run_frame(10, 0, 0);
   endtask

   task automatic test_reset_mid();
      vsync_pulse();
      expect_cap("rst_cap");
      bus.i_cap_done = 1'b1;
      nclk(1);
      bus.i_cap_done = 1'b0;
      nclk(5);
      #2;
      resetn = 1'b0;
      #1;
      checks++;
      if (bus.o_state !== 3'd0 || bus.o_cap_en !== 1'b0 || bus.o_ml_start !== 1'b0 || bus.o_result_vld !== 1'b0 ||
          bus.o_err !== 1'b0 || bus.o_frame_cnt !== 16'd0 || bus.o_drop_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_mid_ml: state %0d cap %b ml %b vld %b err %b frame %0d drop %0d want all 0",
                  bus.o_state, bus.o_cap_en, bus.o_ml_start, bus.o_result_vld, bus.o_err, bus.o_frame_cnt, bus.o_drop_cnt);
      end
      exp_frame = 0;
      exp_drop = 0;
      nclk(1);
      resetn = 1'b1;
      nclk(4);
      checks++;
      if (bus.o_state !== 3'd1) begin
         errors++;
         $display("FAIL reset_release: state %0d want 1", bus.o_state);
      end
   endtask

   initial begin
      bus.i_init_done  = 1'b0;
      bus.i_cam_vsync  = 1'b0;
      bus.i_skip       = 4'd0;
      bus.i_timeout    = 20'd0;
      bus.i_cap_done   = 1'b0;
      bus.i_ml_done    = 1'b0;
      bus.i_result_rdy = 1'b1;
      test_reset();
      test_init_gating();
      test_skip();
      test_busy_drop();
      test_watchdog();
      test_backpressure();
      test_race_cap();
      test_race_ml();
      test_saturation();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
